uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter driving the SoC `ser_tx` pin. It accepts bytes from the CPU-side bus through a valid/ready handshake into a small FIFO and serialises them LSB-first at a programmable bit period. It sits directly upstream of the board serial line and of the testbench serial monitor, which samples at 53-clock half-bit spacing. That spacing is the reason for the 106-clock default bit period.

---
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first, programmable clocks-per-bit divider.
// Define UART_TX_FIFO_EN for a 2^DEPTH_LOG2-entry FIFO; otherwise a single holding register is used.
module uart_tx_fifo #(
  parameter int          DEPTH_LOG2  = 3,
  parameter logic [31:0] DEFAULT_DIV = 32'd106
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_div_we,
  input  logic [31:0]           cfg_div_di,
  output logic [31:0]           cfg_div_do,
  input  logic                  tx_valid,
  input  logic [7:0]            tx_data,
  output logic                  tx_ready,
  output logic                  ser_tx,
  output logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              r_state, w_state_next;
  logic [31:0]         r_div, r_bit_div, r_timer, w_eff_div;
  logic [7:0]          r_shift, w_head;
  logic [2:0]          r_bit_cnt;
  logic                r_ser, w_ser_next;
  logic [DEPTH_LOG2:0] r_level;
  logic                w_push, w_pop, w_load, w_bit_end, w_non_empty;

  assign w_eff_div   = (r_div < 32'd2) ? 32'd2 : r_div;
  assign w_non_empty = (r_level != '0);
  assign w_push      = tx_valid && tx_ready;
  assign w_pop       = w_load;
  assign w_bit_end   = (r_timer == 32'd0);

  always_ff @(posedge clk) begin
    if (reset)           r_div <= DEFAULT_DIV;
    else if (cfg_div_we) r_div <= cfg_div_di;
  end

`ifdef UART_TX_FIFO_EN
  localparam int Depth = 1 << DEPTH_LOG2;

  logic [7:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;

  assign tx_ready = (r_level < (DEPTH_LOG2+1)'(Depth));
  assign w_head   = r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and level are, so flushed entries are never read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end
`else
  logic [7:0] r_hold;

  assign tx_ready = (r_level == '0);
  assign w_head   = r_hold;

  always_ff @(posedge clk) begin
    if (w_push) r_hold <= tx_data;
  end

  // Push and pop can never coincide: a pop needs a full slot, which holds tx_ready low.
  always_ff @(posedge clk) begin
    if (reset)       r_level <= '0;
    else if (w_push) r_level <= (DEPTH_LOG2+1)'(1);
    else if (w_pop)  r_level <= '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_non_empty) w_state_next = S_START;
      S_START: if (w_bit_end) w_state_next = S_DATA;
      S_DATA:  if (w_bit_end && r_bit_cnt == 3'd7) w_state_next = S_STOP;
      S_STOP:  if (w_bit_end) w_state_next = w_non_empty ? S_START : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_load     = 1'b0;
    w_ser_next = r_ser;
    case (r_state)
      S_IDLE: begin
        w_load     = w_non_empty;
        w_ser_next = !w_non_empty;
      end
      S_START: if (w_bit_end) w_ser_next = r_shift[0];
      S_DATA:  if (w_bit_end) w_ser_next = (r_bit_cnt == 3'd7) ? 1'b1 : r_shift[1];
      S_STOP: if (w_bit_end) begin
        w_load     = w_non_empty;
        w_ser_next = !w_non_empty;
      end
      default: w_ser_next = 1'b1;
    endcase
  end

  // The divider is captured per frame so mid-frame writes only take effect at the next start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ser     <= 1'b1;
      r_timer   <= 32'd0;
      r_bit_div <= 32'd2;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_ser <= w_ser_next;
      if (w_load) begin
        r_shift   <= w_head;
        r_bit_div <= w_eff_div;
        r_timer   <= w_eff_div - 32'd1;
        r_bit_cnt <= 3'd0;
      end else if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_timer <= r_bit_div - 32'd1;
          if (r_state == S_DATA) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= r_shift >> 1;
          end
        end else begin
          r_timer <= r_timer - 32'd1;
        end
      end
    end
  end

  assign ser_tx     = r_ser;
  assign tx_busy    = (r_state != S_IDLE) || w_non_empty;
  assign fifo_level = r_level;
  assign cfg_div_do = r_div;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a mid-bit serial receiver decodes frames, timing is measured in clocks.
// Expected FIFO depth follows UART_TX_FIFO_EN (8 when defined, 1 otherwise).
`timescale 1ns/1ps
module tb_uart_tx_fifo;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0, reset = 1'b1, cfg_div_we = 1'b0;
  logic [31:0] cfg_div_di = 32'd0;
  logic [31:0] cfg_div_do;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_ready, ser_tx, tx_busy;
  logic [3:0]  fifo_level;
  int          checks = 0, errors = 0, cyc = 0;

  uart_tx_fifo #(.DEPTH_LOG2(3), .DEFAULT_DIV(32'd106)) dut (
    .clk(clk), .reset(reset),
    .cfg_div_we(cfg_div_we), .cfg_div_di(cfg_div_di), .cfg_div_do(cfg_div_do),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ser_tx(ser_tx), .tx_busy(tx_busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_start(input int budget, output int t, output bit ok);
    int n = 0;
    ok = 1'b0;
    t  = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (ser_tx === 1'b0) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
  endtask

  // Samples each of the 10 bit cells in the middle; word = {stop, data, start}.
  task automatic rx_frame(input int div, input int budget, output logic [9:0] word,
                          output int t, output bit ok);
    word = '1;
    wait_start(budget, t, ok);
    if (ok) begin
      repeat (div / 2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        word[k] = ser_tx;
        if (k < 9) repeat (div) @(negedge clk);
      end
    end
  endtask

  // Called on a negedge; holds tx_valid until each byte is taken, tracking the level peak.
  task automatic push_seq(input logic [7:0] data [16], input int n, input int budget,
                          output int peak, output int bad, output int acc [16], output bit ok);
    int waited;
    peak = 0;
    bad  = 0;
    ok   = 1'b1;
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1;
      tx_data  = data[i];
      waited   = 0;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (tx_ready !== (int'(fifo_level) < DEPTH)) bad++;
      while (tx_ready !== 1'b1 && waited < budget) begin
        @(negedge clk);
        waited++;
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        if (tx_ready !== (int'(fifo_level) < DEPTH)) bad++;
      end
      if (tx_ready !== 1'b1) ok = 1'b0;
      acc[i] = cyc + 1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  endtask

  task automatic cfg_write(input logic [31:0] v);
    @(negedge clk);
    cfg_div_di = v;
    cfg_div_we = 1'b1;
    @(negedge clk);
    cfg_div_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL reset_ser_tx got %0b exp 1", ser_tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %0b exp 1", tx_ready); end
    checks++; if (cfg_div_do !== 32'd106) begin errors++; $display("FAIL reset_div got %0d exp 106", cfg_div_do); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", tx_busy); end
  endtask

  task automatic test_first_byte;
    logic [7:0] d [16];
    int acc [16];
    int peak, bad, t;
    bit pok, rok;
    logic [9:0] w;
    d[0] = 8'h41;
    @(negedge clk);
    fork
      push_seq(d, 1, 50, peak, bad, acc, pok);
      rx_frame(106, 200, w, t, rok);
    join
    checks++; if (!(pok && rok)) begin errors++; $display("FAIL first_timeout got push=%0b rx=%0b exp 1 1", pok, rok); end
    checks++; if (w !== {1'b1, 8'h41, 1'b0}) begin errors++; $display("FAIL first_frame got %h exp %h", w, {1'b1, 8'h41, 1'b0}); end
    checks++; if (t !== acc[0] + 1) begin errors++; $display("FAIL first_latency got %0d exp %0d", t - acc[0], 1); end
    repeat (52) @(negedge clk);
    checks++; if ({ser_tx, tx_busy} !== 2'b11) begin errors++; $display("FAIL first_last_stop got ser=%0b busy=%0b exp 1 1", ser_tx, tx_busy); end
    @(negedge clk);
    checks++; if ({ser_tx, tx_busy} !== 2'b10) begin errors++; $display("FAIL first_frame_end got ser=%0b busy=%0b exp 1 0", ser_tx, tx_busy); end
  endtask

  task automatic test_back_to_back;
    string s = "Hello\n";
    logic [7:0] d [16];
    int acc [16];
    logic [9:0] w [6];
    int t [6];
    int peak, bad;
    bit pok, rok;
    for (int i = 0; i < 6; i++) d[i] = s[i];
    rok = 1'b1;
    @(negedge clk);
    fork
      push_seq(d, 6, 2500, peak, bad, acc, pok);
      for (int i = 0; i < 6; i++) begin
        bit ok1;
        rx_frame(106, 1200, w[i], t[i], ok1);
        if (!ok1) rok = 1'b0;
      end
    join
    checks++; if (!(pok && rok)) begin errors++; $display("FAIL burst_timeout got push=%0b rx=%0b exp 1 1", pok, rok); end
    checks++; if (peak !== (DEPTH >= 5 ? 5 : DEPTH)) begin errors++; $display("FAIL burst_peak got %0d exp %0d", peak, (DEPTH >= 5 ? 5 : DEPTH)); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL burst_ready got %0d exp 0 bad cycles", bad); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (w[i] !== {1'b1, d[i], 1'b0}) begin errors++; $display("FAIL burst_byte%0d got %h exp %h", i, w[i], {1'b1, d[i], 1'b0}); end
    end
    for (int i = 1; i < 6; i++) begin
      checks++; if (t[i] - t[i-1] !== 1060) begin errors++; $display("FAIL burst_gap%0d got %0d exp 1060", i, t[i] - t[i-1]); end
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_full;
    logic [7:0] d [16];
    int acc [16];
    logic [9:0] w [10];
    int t [10];
    int peak, bad;
    bit pok, rok;
    for (int i = 0; i < 10; i++) d[i] = 8'(i);
    rok = 1'b1;
    @(negedge clk);
    fork
      push_seq(d, 10, 1500, peak, bad, acc, pok);
      for (int i = 0; i < 10; i++) begin
        bit ok1;
        rx_frame(106, 1200, w[i], t[i], ok1);
        if (!ok1) rok = 1'b0;
      end
    join
    checks++; if (!(pok && rok)) begin errors++; $display("FAIL full_timeout got push=%0b rx=%0b exp 1 1", pok, rok); end
    checks++; if (peak !== DEPTH) begin errors++; $display("FAIL full_peak got %0d exp %0d", peak, DEPTH); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_ready got %0d exp 0 bad cycles", bad); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (w[i] !== {1'b1, d[i], 1'b0}) begin errors++; $display("FAIL full_byte%0d got %h exp %h", i, w[i], {1'b1, d[i], 1'b0}); end
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_divider;
    logic [7:0] d [16];
    int acc [16];
    logic [9:0] w1, w2;
    int t1, t2, peak, bad;
    bit pok, r1, r2;
    d[0] = 8'h3C;
    d[1] = 8'hC3;
    @(negedge clk);
    fork
      push_seq(d, 2, 1500, peak, bad, acc, pok);
      begin
        rx_frame(106, 200, w1, t1, r1);
        rx_frame(10, 1200, w2, t2, r2);
      end
      begin
        repeat (300) @(negedge clk);
        cfg_write(32'd10);
      end
    join
    checks++; if (!(pok && r1 && r2)) begin errors++; $display("FAIL div_timeout got %0b%0b%0b exp 111", pok, r1, r2); end
    checks++; if (cfg_div_do !== 32'd10) begin errors++; $display("FAIL div_readback got %0d exp 10", cfg_div_do); end
    checks++; if (w1 !== {1'b1, 8'h3C, 1'b0}) begin errors++; $display("FAIL div_old_frame got %h exp %h", w1, {1'b1, 8'h3C, 1'b0}); end
    checks++; if (t2 - t1 !== 1060) begin errors++; $display("FAIL div_old_len got %0d exp 1060", t2 - t1); end
    checks++; if (w2 !== {1'b1, 8'hC3, 1'b0}) begin errors++; $display("FAIL div_new_frame got %h exp %h", w2, {1'b1, 8'hC3, 1'b0}); end
    repeat (4) @(negedge clk);
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL div10_last_stop got busy=%0b exp 1", tx_busy); end
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL div10_end got busy=%0b exp 0", tx_busy); end

    cfg_write(32'd1);
    checks++; if (cfg_div_do !== 32'd1) begin errors++; $display("FAIL div1_readback got %0d exp 1", cfg_div_do); end
    d[0] = 8'h96;
    d[1] = 8'h69;
    fork
      push_seq(d, 2, 100, peak, bad, acc, pok);
      begin
        rx_frame(2, 100, w1, t1, r1);
        rx_frame(2, 100, w2, t2, r2);
      end
    join
    checks++; if (!(pok && r1 && r2)) begin errors++; $display("FAIL div1_timeout got %0b%0b%0b exp 111", pok, r1, r2); end
    checks++; if (w1 !== {1'b1, 8'h96, 1'b0}) begin errors++; $display("FAIL div1_frame0 got %h exp %h", w1, {1'b1, 8'h96, 1'b0}); end
    checks++; if (w2 !== {1'b1, 8'h69, 1'b0}) begin errors++; $display("FAIL div1_frame1 got %h exp %h", w2, {1'b1, 8'h69, 1'b0}); end
    checks++; if (t2 - t1 !== 20) begin errors++; $display("FAIL div1_len got %0d exp 20", t2 - t1); end
    repeat (10) @(negedge clk);
    cfg_write(32'd106);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d [16];
    int acc [16];
    int n, t, t2, peak, bad;
    bit pok, sok, late;
    n = (DEPTH >= 4) ? 5 : DEPTH + 1;
    d[0] = 8'hF7;
    for (int i = 1; i < 5; i++) d[i] = 8'(8'h10 + i);
    @(negedge clk);
    fork
      push_seq(d, n, 100, peak, bad, acc, pok);
      wait_start(100, t, sok);
    join
    checks++; if (!(pok && sok)) begin errors++; $display("FAIL mid_timeout got push=%0b start=%0b exp 1 1", pok, sok); end
    repeat (4 * 106 + 53 - (cyc - t)) @(negedge clk);
    checks++; if ({ser_tx, tx_busy} !== 2'b01) begin errors++; $display("FAIL mid_bit3 got ser=%0b busy=%0b exp 0 1", ser_tx, tx_busy); end
    checks++; if (int'(fifo_level) !== n - 1) begin errors++; $display("FAIL mid_queued got %0d exp %0d", fifo_level, n - 1); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({ser_tx, tx_ready, tx_busy} !== 3'b110) begin errors++; $display("FAIL mid_after_reset got ser=%0b ready=%0b busy=%0b exp 1 1 0", ser_tx, tx_ready, tx_busy); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL mid_flush got %0d exp 0", fifo_level); end
    checks++; if (cfg_div_do !== 32'd106) begin errors++; $display("FAIL mid_div got %0d exp 106", cfg_div_do); end
    wait_start(3000, t2, late);
    checks++; if (late !== 1'b0) begin errors++; $display("FAIL mid_no_start got start at cycle %0d exp none", t2); end
  endtask

  task automatic test_pair;
    logic [7:0] d [16];
    int acc [16];
    logic [9:0] w1, w2;
    int t1, t2, peak, bad;
    bit pok, r1, r2;
    d[0] = 8'h55;
    d[1] = 8'hAA;
    @(negedge clk);
    fork
      push_seq(d, 2, 1500, peak, bad, acc, pok);
      begin
        rx_frame(106, 200, w1, t1, r1);
        rx_frame(106, 1200, w2, t2, r2);
      end
    join
    checks++; if (!(pok && r1 && r2)) begin errors++; $display("FAIL pair_timeout got %0b%0b%0b exp 111", pok, r1, r2); end
    checks++; if (acc[1] - acc[0] !== (DEPTH == 1 ? 2 : 1)) begin errors++; $display("FAIL pair_accept_gap got %0d exp %0d", acc[1] - acc[0], (DEPTH == 1 ? 2 : 1)); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pair_ready got %0d exp 0 bad cycles", bad); end
    checks++; if (w1 !== {1'b1, 8'h55, 1'b0}) begin errors++; $display("FAIL pair_byte0 got %h exp %h", w1, {1'b1, 8'h55, 1'b0}); end
    checks++; if (w2 !== {1'b1, 8'hAA, 1'b0}) begin errors++; $display("FAIL pair_byte1 got %h exp %h", w2, {1'b1, 8'hAA, 1'b0}); end
    checks++; if (t2 - t1 !== 1060) begin errors++; $display("FAIL pair_gap got %0d exp 1060", t2 - t1); end
  endtask

  initial begin
    test_reset();
    test_first_byte();
    test_back_to_back();
    test_full();
    test_divider();
    test_reset_mid_frame();
    test_pair();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
